// File: rtl/broadcast_arbitration_unit.sv
`default_nettype none
// ============================================================================
// Module   : broadcast_arbitration_unit
// Purpose  : Round-robin arbiter for a multi-cycle result broadcast bus, plus
//            the pipeline halt / decode-enable generator. A starvation counter
//            forces a decode slot after a bounded run of broadcast cycles.
// Revision : 1.0 - initial release
// ============================================================================
module broadcast_arbitration_unit #(
  parameter int NUM_BCAST    = 4,
  parameter int BCAST_CYCLES = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int NUM_QUEUES   = 2,
  parameter int IDX_W        = (NUM_BCAST > 1) ? $clog2(NUM_BCAST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BCAST-1:0]  i_bcast_req,
  input  logic                  i_ROB_full,
  input  logic [NUM_QUEUES-1:0] i_queueFull,
  output logic [NUM_BCAST-1:0]  o_bcast_grant,
  output logic [IDX_W-1:0]      o_bcast_grant_idx,
  output logic                  o_ongoingBroadcast,
  output logic                  o_allowDecode,
  output logic                  o_allowBroadcast,
  output logic                  o_IF_halt,
  output logic                  o_RF_halt,
  output logic                  o_DecodeROBPipeline_halt,
  output logic                  o_ROB_halt,
  output logic                  o_Dispatch_halt,
  output logic                  o_starve_force
);

  localparam int CNT_W = $clog2(BCAST_CYCLES + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0]       c_IDLE       = 1'b0;
  localparam logic [0:0]       c_BCAST      = 1'b1;
  localparam logic [CNT_W-1:0] c_CNT_LOAD   = CNT_W'(BCAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(1);
  localparam logic [STV_W-1:0] c_STARVE_MAX = STV_W'(STARVE_LIMIT);

  // Wrap an index into the requester range
  function automatic logic [IDX_W-1:0] f_wrap(input int v);
    return IDX_W'(v % NUM_BCAST);
  endfunction

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_bcast_cnt;
  logic [STV_W-1:0]     r_starve_cnt;
  logic [NUM_BCAST-1:0] r_grant_q;
  logic [IDX_W-1:0]     r_grant_idx;

  logic                 w_stall;
  logic                 w_force;
  logic                 w_fire;
  logic                 w_busy;
  logic                 w_win_found;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_BCAST-1:0] w_win_oh;
  logic                 w_front_halt;

  assign w_stall = i_ROB_full | (|i_queueFull);

  // A forced decode slot only happens on an idle bus with downstream room;
  // stall cycles never count towards it, so a full ROB cannot deadlock here.
  assign w_force = !rst && (r_state == c_IDLE) && (r_starve_cnt == c_STARVE_MAX) && !w_stall;
  assign w_fire  = !rst && (r_state == c_IDLE) && (|i_bcast_req) && !w_force;
  assign w_busy  = w_fire || (r_state == c_BCAST);

  // Round-robin winner: first requester at or after r_rr_ptr, cyclically
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < NUM_BCAST; i++) begin
      if (!w_win_found && i_bcast_req[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_win_found = 1'b1;
        w_win_idx   = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  // One-hot form of the winner
  always_comb begin
    w_win_oh = '0;
    if (w_win_found) w_win_oh[w_win_idx] = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: single-cycle broadcasts never leave IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_fire && (BCAST_CYCLES > 1)) w_state_nxt = c_BCAST;
      c_BCAST: if (r_bcast_cnt == c_CNT_LAST) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM outputs: busy bus beats a stall, which beats normal decode
  always_comb begin
    o_allowDecode    = 1'b1;
    o_allowBroadcast = 1'b0;
    w_front_halt     = 1'b0;
    o_Dispatch_halt  = 1'b0;
    if (w_busy) begin
      o_allowDecode    = 1'b0;
      o_allowBroadcast = 1'b1;
      w_front_halt     = 1'b1;
      o_Dispatch_halt  = 1'b1;
    end else if (w_stall && !rst) begin
      o_allowDecode    = 1'b0;
      o_allowBroadcast = 1'b1;
      w_front_halt     = 1'b1;
    end
  end

  // Grant is combinational in the firing cycle, latched for the rest
  always_comb begin
    o_bcast_grant     = '0;
    o_bcast_grant_idx = '0;
    if (w_fire) begin
      o_bcast_grant     = w_win_oh;
      o_bcast_grant_idx = w_win_idx;
    end else if (r_state == c_BCAST) begin
      o_bcast_grant     = r_grant_q;
      o_bcast_grant_idx = r_grant_idx;
    end
  end

  assign o_IF_halt                = w_front_halt;
  assign o_RF_halt                = w_front_halt;
  assign o_DecodeROBPipeline_halt = w_front_halt;
  assign o_ROB_halt               = 1'b0;
  assign o_ongoingBroadcast       = (r_state == c_BCAST);
  assign o_starve_force           = w_force;

  // Latch the grant, advance the round-robin pointer and run the beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_grant_q   <= '0;
      r_grant_idx <= '0;
      r_bcast_cnt <= '0;
    end else if (w_fire) begin
      r_rr_ptr    <= f_wrap(int'(w_win_idx) + 1);
      r_grant_q   <= w_win_oh;
      r_grant_idx <= w_win_idx;
      r_bcast_cnt <= c_CNT_LOAD;
    end else if ((r_state == c_BCAST) && (r_bcast_cnt != '0)) begin
      r_bcast_cnt <= r_bcast_cnt - c_CNT_LAST;
    end
  end

  // Starvation counter: counts unstalled broadcast cycles, cleared by decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (o_allowDecode) begin
      r_starve_cnt <= '0;
    end else if ((|o_bcast_grant) && !w_stall && (r_starve_cnt != c_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + STV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_broadcast_arbitration_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_broadcast_arbitration_unit
// Purpose  : Directed self-checking bench for broadcast_arbitration_unit,
//            using default, short-starvation and single-cycle-bus instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_broadcast_arbitration_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rob = 1'b0;
  logic [1:0] qf  = 2'b00;

  int n_assert = 0;
  int n_fail   = 0;

  // default instance outputs
  logic [3:0] d_grant; logic [1:0] d_idx;
  logic d_ongo, d_ad, d_ab, d_if, d_rf, d_dp, d_rob, d_dis, d_sf;
  // STARVE_LIMIT=4 instance outputs
  logic [3:0] s_grant; logic [1:0] s_idx;
  logic s_ongo, s_ad, s_ab, s_if, s_rf, s_dp, s_rob, s_dis, s_sf;
  // BCAST_CYCLES=1 instance outputs
  logic [3:0] b_grant; logic [1:0] b_idx;
  logic b_ongo, b_ad, b_ab, b_if, b_rf, b_dp, b_rob, b_dis, b_sf;

  always #5 clk = ~clk;

  broadcast_arbitration_unit u_def (
    .clk(clk), .rst(rst), .i_bcast_req(req), .i_ROB_full(rob), .i_queueFull(qf),
    .o_bcast_grant(d_grant), .o_bcast_grant_idx(d_idx), .o_ongoingBroadcast(d_ongo),
    .o_allowDecode(d_ad), .o_allowBroadcast(d_ab), .o_IF_halt(d_if), .o_RF_halt(d_rf),
    .o_DecodeROBPipeline_halt(d_dp), .o_ROB_halt(d_rob), .o_Dispatch_halt(d_dis),
    .o_starve_force(d_sf));

  broadcast_arbitration_unit #(.STARVE_LIMIT(4)) u_sl4 (
    .clk(clk), .rst(rst), .i_bcast_req(req), .i_ROB_full(rob), .i_queueFull(qf),
    .o_bcast_grant(s_grant), .o_bcast_grant_idx(s_idx), .o_ongoingBroadcast(s_ongo),
    .o_allowDecode(s_ad), .o_allowBroadcast(s_ab), .o_IF_halt(s_if), .o_RF_halt(s_rf),
    .o_DecodeROBPipeline_halt(s_dp), .o_ROB_halt(s_rob), .o_Dispatch_halt(s_dis),
    .o_starve_force(s_sf));

  broadcast_arbitration_unit #(.BCAST_CYCLES(1)) u_bc1 (
    .clk(clk), .rst(rst), .i_bcast_req(req), .i_ROB_full(rob), .i_queueFull(qf),
    .o_bcast_grant(b_grant), .o_bcast_grant_idx(b_idx), .o_ongoingBroadcast(b_ongo),
    .o_allowDecode(b_ad), .o_allowBroadcast(b_ab), .o_IF_halt(b_if), .o_RF_halt(b_rf),
    .o_DecodeROBPipeline_halt(b_dp), .o_ROB_halt(b_rob), .o_Dispatch_halt(b_dis),
    .o_starve_force(b_sf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; rob = 1'b0; qf = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sf_def, sf_sl4, sf_bc1;
    logic [1:0] exp_def [0:7];
    exp_def = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 3'd3, 2'd3};

    // ---------------- reset state (requests present during reset) ----------
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("rst_grant", d_grant, 4'b0000);
    chk("rst_idx", d_idx, 2'd0);
    chk("rst_ongo", d_ongo, 1'b0);
    chk("rst_ad", d_ad, 1'b1);
    chk("rst_ab", d_ab, 1'b0);
    chk("rst_ifh", d_if, 1'b0);
    chk("rst_dis", d_dis, 1'b0);
    chk("rst_sf", d_sf, 1'b0);

    // ---------------- single request, 2-cycle broadcast ---------------------
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    chk("t1c0_grant", d_grant, 4'b0100);
    chk("t1c0_idx", d_idx, 2'd2);
    chk("t1c0_ongo", d_ongo, 1'b0);
    chk("t1c0_ad", d_ad, 1'b0);
    chk("t1c0_dis", d_dis, 1'b1);
    chk("t1c0_rob", d_rob, 1'b0);
    step(); req = 4'b0000;
    @(negedge clk);
    chk("t1c1_grant", d_grant, 4'b0100);
    chk("t1c1_ongo", d_ongo, 1'b1);
    chk("t1c1_ad", d_ad, 1'b0);
    step();
    @(negedge clk);
    chk("t1c2_grant", d_grant, 4'b0000);
    chk("t1c2_ongo", d_ongo, 1'b0);
    chk("t1c2_ad", d_ad, 1'b1);
    chk("t1c2_ab", d_ab, 1'b0);
    step(); req = 4'b1001;
    @(negedge clk);
    chk("t1c3_rrptr_idx", d_idx, 2'd3);
    chk("t1c3_grant", d_grant, 4'b1000);

    // ---------------- all requesting: rotation and starvation ---------------
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) begin
        chk($sformatf("t2_def_idx_c%0d", c), d_idx, exp_def[c]);
        chk($sformatf("t2_def_ongo_c%0d", c), d_ongo, c % 2);
        chk($sformatf("t2_def_sf_c%0d", c), d_sf, 1'b0);
      end else if (c == 8) begin
        chk("t2_def_force_sf", d_sf, 1'b1);
        chk("t2_def_force_grant", d_grant, 4'b0000);
        chk("t2_def_force_ad", d_ad, 1'b1);
      end else begin
        chk("t2_def_after_idx", d_idx, 2'd0);
        chk("t2_def_after_grant", d_grant, 4'b0001);
      end
      if (c < 4) begin
        chk($sformatf("t2_sl4_idx_c%0d", c), s_idx, c / 2);
        chk($sformatf("t2_sl4_sf_c%0d", c), s_sf, 1'b0);
      end else if (c == 4) begin
        chk("t2_sl4_force_sf", s_sf, 1'b1);
        chk("t2_sl4_force_grant", s_grant, 4'b0000);
        chk("t2_sl4_force_ad", s_ad, 1'b1);
      end else if (c == 5) begin
        chk("t2_sl4_after_idx", s_idx, 2'd2);
        chk("t2_sl4_after_sf", s_sf, 1'b0);
      end
      step();
    end

    // ---------------- stall handling ----------------------------------------
    do_reset();
    qf = 2'b10;
    @(negedge clk);
    chk("t3_qf_ad", d_ad, 1'b0);
    chk("t3_qf_ab", d_ab, 1'b1);
    chk("t3_qf_ifh", d_if, 1'b1);
    chk("t3_qf_dis", d_dis, 1'b0);
    step(); qf = 2'b00; rob = 1'b1;
    @(negedge clk);
    chk("t3_rob_ad", d_ad, 1'b0);
    chk("t3_rob_ab", d_ab, 1'b1);
    chk("t3_rob_ifh", d_if, 1'b1);
    chk("t3_rob_rfh", d_rf, 1'b1);
    chk("t3_rob_dph", d_dp, 1'b1);
    chk("t3_rob_robh", d_rob, 1'b0);
    chk("t3_rob_dis", d_dis, 1'b0);
    step(); req = 4'b0010;
    @(negedge clk);
    chk("t3_req_grant", d_grant, 4'b0010);
    chk("t3_req_dis", d_dis, 1'b1);
    step(); req = 4'b1111;
    sf_def = 0; sf_sl4 = 0; sf_bc1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sf_def += int'(d_sf); sf_sl4 += int'(s_sf); sf_bc1 += int'(b_sf);
      step();
    end
    chk("t3_nostarve_def", sf_def, 0);
    chk("t3_nostarve_sl4", sf_sl4, 0);
    chk("t3_nostarve_bc1", sf_bc1, 0);

    // ---------------- async reset mid-broadcast -----------------------------
    do_reset();
    req = 4'b0100;
    step(); req = 4'b0000;
    @(negedge clk);
    chk("t4_mid_grant", d_grant, 4'b0100);
    chk("t4_mid_ongo", d_ongo, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_grant", d_grant, 4'b0000);
    chk("t4_rst_ongo", d_ongo, 1'b0);
    chk("t4_rst_ad", d_ad, 1'b1);
    chk("t4_rst_ifh", d_if, 1'b0);
    step(); rst = 1'b0; req = 4'b1100;
    @(negedge clk);
    chk("t4_rel_idx", d_idx, 2'd2);
    chk("t4_rel_grant", d_grant, 4'b0100);
    step(); req = 4'b0000;
    step(); req = 4'b1000;
    @(negedge clk);
    chk("t4_req8_idx", d_idx, 2'd3);
    chk("t4_req8_grant", d_grant, 4'b1000);

    // ---------------- single-cycle bus: alternating grants ------------------
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t5_bc1_idx_c%0d", c), b_idx, c % 2);
      chk($sformatf("t5_bc1_grant_c%0d", c), b_grant, (c % 2) ? 4'b0010 : 4'b0001);
      chk($sformatf("t5_bc1_ongo_c%0d", c), b_ongo, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
